// File: rtl/snapshot_fifo_if.sv
// Valid/ready stream carrying queued snapshot values from the FIFO to the host-side reader.
interface snapshot_fifo_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/snapshot_fifo.sv
// Watches the snapshot bus, queues every changed value in a small FIFO and drains it
// over a valid/ready stream; values arriving while full are dropped and counted.
module snapshot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OVF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     en,
    snapshot_fifo_if.master          drain,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     chg,
    output logic [OVF_W-1:0]         ovf_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] prev;
    logic             primed;
    logic             push_req;
    logic             pop;
    logic             push;
    logic             drop;
    logic             valid;

    // Pointers carry one extra bit so a full FIFO and an empty one differ.
    always_comb begin
        level    = wr_ptr - rd_ptr;
        full     = (level == PW'(DEPTH));
        valid    = (level != '0);
        push_req = en && (!primed || (din != prev));
        pop      = valid && drain.ready;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    assign drain.valid = valid;
    assign drain.data  = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            prev    <= '0;
            primed  <= 1'b0;
            chg     <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (en) begin
                prev   <= din;
                primed <= 1'b1;
            end
            chg <= push_req;
            if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: tb/tb_snapshot_fifo.sv
// Randomised and directed stimulus for snapshot_fifo, checked by a queue-based
// reference model and a scoreboard monitor sampling on the falling edge.
module tb_snapshot_fifo;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int OVF_W   = 8;
    localparam int OVF_MAX = (1 << OVF_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [WIDTH-1:0]      din;
    logic [$clog2(DEPTH):0] level;
    logic                  full;
    logic                  chg;
    logic [OVF_W-1:0]      ovf_cnt;

    snapshot_fifo_if #(.WIDTH(WIDTH)) bus ();

    snapshot_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .en      (en),
        .drain   (bus),
        .level   (level),
        .full    (full),
        .chg     (chg),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_prev;
    bit               m_primed;
    bit               m_chg;
    int               m_ovf;
    int               n_checks = 0;
    int               n_errors = 0;
    bit               mon_on   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs still held on the pins.
    function automatic void modelEdge();
        bit preq;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_prev   = '0;
            m_primed = 1'b0;
            m_chg    = 1'b0;
            m_ovf    = 0;
        end else begin
            preq = en && (!m_primed || (din != m_prev));
            if (mq.size() > 0 && bus.ready) void'(mq.pop_front());
            if (preq) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(din);
                    exp_q.push_back(din);
                end else if (m_ovf < OVF_MAX) begin
                    m_ovf++;
                end
            end
            m_chg = preq;
            if (en) begin
                m_prev   = din;
                m_primed = 1'b1;
            end
        end
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic [WIDTH-1:0] d, input logic rdy);
        @(posedge clk);
        #2;
        modelEdge();
        rst       = r;
        en        = e;
        din       = d;
        bus.ready = rdy;
    endtask

    // Scoreboard monitor: compares status against the model and pops on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                checkOutput("level", 32'(level), 32'(mq.size()));
                checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
                checkOutput("valid", 32'(bus.valid), 32'(mq.size() != 0));
                checkOutput("chg", 32'(chg), 32'(m_chg));
                checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
                if (bus.valid && bus.ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("[TB] FAIL pop_empty: got pop of %0h, expected no data at %0t", bus.data, $time);
                    end else begin
                        checkOutput("pop_data", 32'(bus.data), 32'(exp_q.pop_front()));
                    end
                end else begin
                    checkOutput("head_data", 32'(bus.data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bias;
        rst       = 1'b1;
        en        = 1'b0;
        din       = '0;
        bus.ready = 1'b0;

        applyStimulus(1, 0, 8'h00, 0);
        mon_on = 1'b1;
        checkOutput("reset_valid", 32'(bus.valid), 32'h0);
        checkOutput("reset_data", 32'(bus.data), 32'h0);

        // Constant 00 after reset yields exactly one entry.
        applyStimulus(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h00, 0);
        checkOutput("t1_level", 32'(level), 32'h1);
        checkOutput("t1_data", 32'(bus.data), 32'h00);

        // Five distinct values into an empty FIFO: four stored, one dropped.
        applyStimulus(1, 0, 8'h00, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 8'(i), 0);
        applyStimulus(0, 1, 8'h05, 0);
        checkOutput("t2_full", 32'(full), 32'h1);
        checkOutput("t2_ovf", 32'(ovf_cnt), 32'h1);
        checkOutput("t2_data", 32'(bus.data), 32'h01);

        // Pop and push on the same edge while full.
        applyStimulus(0, 1, 8'hAA, 1);
        applyStimulus(0, 1, 8'hAA, 0);
        checkOutput("t3_level", 32'(level), 32'h4);
        checkOutput("t3_ovf", 32'(ovf_cnt), 32'h1);
        checkOutput("t3_data", 32'(bus.data), 32'h02);

        // Disabled sampling, then re-enable on the last sampled value.
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'($urandom), 0);
        applyStimulus(0, 1, 8'hAA, 0);
        applyStimulus(0, 1, 8'hAA, 0);
        checkOutput("t4_chg", 32'(chg), 32'h0);
        checkOutput("t4_level", 32'(level), 32'h4);

        // Saturate the drop counter.
        for (int i = 0; i < 300; i++) applyStimulus(0, 1, 8'(i), 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t5_ovf", 32'(ovf_cnt), 32'hFF);

        // Reset with three entries queued.
        applyStimulus(1, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h10, 0);
        applyStimulus(0, 1, 8'h11, 0);
        applyStimulus(0, 1, 8'h12, 0);
        applyStimulus(1, 0, 8'h00, 0);
        checkOutput("t6_level3", 32'(level), 32'h3);
        applyStimulus(0, 1, 8'h77, 0);
        checkOutput("t6_level0", 32'(level), 32'h0);
        checkOutput("t6_valid", 32'(bus.valid), 32'h0);
        checkOutput("t6_ovf", 32'(ovf_cnt), 32'h0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t6_first", 32'(bus.data), 32'h77);

        // Random traffic with phases of varying reader throughput.
        for (int i = 0; i < 2000; i++) begin
            bias = (i / 250) % 4;
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 7) != 0,
                          8'($urandom_range(0, 3)),
                          $urandom_range(0, 3) < bias);
        end
        applyStimulus(0, 0, 8'h00, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end
endmodule
